// File: rtl/display_pkg.sv
// Shared types and constants for the raster scan controller.
// Holds the scan FSM encoding, buffer indices and the channel-select width helper.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VBLANK = 2'd1,
        ST_HBLANK = 2'd2,
        ST_ACTIVE = 2'd3
    } scan_state_e;

    localparam logic       BUF_0         = 1'b0;
    localparam logic       BUF_1         = 1'b1;
    localparam logic [1:0] BUF_ALL_EMPTY = 2'b11;

    // Keeps the channel selector at least one bit wide even for a single channel.
    function automatic int chan_width(input int nchan);
        return (nchan > 1) ? $clog2(nchan) : 1;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Channel / pixel / line counters for the raster scan, with terminal-count flags.
// The pixel counter spans the whole line (blanking plus active pixels).
module scan_counter
    import display_pkg::*;
#(
    parameter int NCHAN = 3,
    parameter int CW    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         advance,
    input  logic [CW:0]                  px_max,
    input  logic [CW-1:0]                line_max,
    output logic [chan_width(NCHAN)-1:0] chan,
    output logic [CW:0]                  px,
    output logic                         chan_tc,
    output logic                         line_end,
    output logic                         region_end
);
    localparam int             CHW       = chan_width(NCHAN);
    localparam logic [CHW-1:0] CHAN_LAST = CHW'(NCHAN - 1);

    logic [CHW-1:0] chan_q, chan_d;
    logic [CW:0]    px_q, px_d;
    logic [CW-1:0]  line_q, line_d;

    // Flags describe the slot currently held in the counters.
    assign chan_tc    = (chan_q == CHAN_LAST);
    assign line_end   = chan_tc && (px_q == px_max);
    assign region_end = line_end && (line_q == line_max);

    always_comb begin
        chan_d = chan_q;
        px_d   = px_q;
        line_d = line_q;
        if (clear) begin
            chan_d = '0;
            px_d   = '0;
            line_d = '0;
        end else if (advance) begin
            if (chan_tc) begin
                chan_d = '0;
                if (px_q == px_max) begin
                    px_d   = '0;
                    line_d = (line_q == line_max) ? '0 : line_q + CW'(1);
                end else begin
                    px_d = px_q + (CW+1)'(1);
                end
            end else begin
                chan_d = chan_q + CHW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            chan_q <= '0;
            px_q   <= '0;
            line_q <= '0;
        end else begin
            chan_q <= chan_d;
            px_q   <= px_d;
            line_q <= line_d;
        end
    end

    assign chan = chan_q;
    assign px   = px_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Double-buffered raster scan controller: blanking/active timing, sync pulses,
// frame-buffer read strobes, and read/write buffer swapping at frame boundaries.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int NCHAN = 3,
    parameter int CW    = 10,
    parameter int AW    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         display_en,
    input  logic                         wr_done,
    input  logic [CW-1:0]                vb_lines,
    input  logic [CW-1:0]                hb_px,
    input  logic [CW-1:0]                act_px,
    input  logic [CW-1:0]                act_lines,
    output logic                         rd_en,
    output logic [AW-1:0]                rd_addr,
    output logic                         rd_buf,
    output logic                         wr_buf,
    output logic [1:0]                   buf_empty,
    output logic [chan_width(NCHAN)-1:0] chan_sel,
    output logic                         blank,
    output logic                         hsync,
    output logic                         vsync
);
    localparam int CHW = chan_width(NCHAN);

    scan_state_e   state_q, state_d;
    scan_state_e   first_state, line_state;
    logic [CW-1:0] vb_q, vb_d, hb_q, hb_d, ap_q, ap_d, al_q, al_d;
    logic [CW-1:0] ap_in, al_in;
    logic          rd_buf_q, rd_buf_d, wr_buf_q, wr_buf_d;
    logic [1:0]    buf_empty_q, buf_empty_d, empty_eff;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_en_q, rd_en_d, blank_q, blank_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d;
    logic          frame_start, swap, cnt_clear, cnt_advance;

    logic [CHW-1:0] chan;
    logic [CW:0]    px, px_max, hb_last;
    logic [CW-1:0]  line_max;
    logic           chan_tc, line_end, region_end;

    // Timing limits come from the configuration latched at frame start.
    assign px_max   = {1'b0, hb_q} + {1'b0, ap_q} - (CW+1)'(1);
    assign hb_last  = {1'b0, hb_q} - (CW+1)'(1);
    assign line_max = (state_q == ST_VBLANK) ? vb_q - CW'(1) : al_q - CW'(1);

    scan_counter #(
        .NCHAN (NCHAN),
        .CW    (CW)
    ) u_scan_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .advance    (cnt_advance),
        .px_max     (px_max),
        .line_max   (line_max),
        .chan       (chan),
        .px         (px),
        .chan_tc    (chan_tc),
        .line_end   (line_end),
        .region_end (region_end)
    );

    // A wr_done arriving together with a frame-end decision already counts for it.
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
        assign empty_eff[gi]   = buf_empty_q[gi] & ~(wr_done & (wr_buf_q == 1'(gi)));
        assign buf_empty_d[gi] = empty_eff[gi] | (swap & (rd_buf_q == 1'(gi)));
    end

    always_comb begin
        ap_in = (act_px == '0) ? CW'(1) : act_px;
        al_in = (act_lines == '0) ? CW'(1) : act_lines;
        if (vb_lines != '0) begin
            first_state = ST_VBLANK;
        end else if (hb_px != '0) begin
            first_state = ST_HBLANK;
        end else begin
            first_state = ST_ACTIVE;
        end
        line_state = (hb_q != '0) ? ST_HBLANK : ST_ACTIVE;

        state_d     = state_q;
        frame_start = 1'b0;
        swap        = 1'b0;
        hsync_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (display_en && !buf_empty_q[0]) begin
                    frame_start = 1'b1;
                    swap        = 1'b1;
                end
            end
            ST_VBLANK: begin
                if (region_end) begin
                    state_d = line_state;
                    hsync_d = 1'b1;
                end
            end
            ST_HBLANK: begin
                if (chan_tc && (px == hb_last)) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (region_end) begin
                    if (!display_en) begin
                        state_d = ST_IDLE;
                    end else begin
                        frame_start = 1'b1;
                        swap        = !empty_eff[wr_buf_q];
                    end
                end else if (line_end) begin
                    state_d = line_state;
                    hsync_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The first slot of a frame is also an active-region line start when vb_lines=0.
        if (frame_start) begin
            state_d = first_state;
            hsync_d = (vb_lines == '0);
        end
        vsync_d = frame_start;

        rd_en_d     = (state_d == ST_ACTIVE);
        blank_d     = !rd_en_d;
        cnt_clear   = frame_start || (state_d == ST_IDLE);
        cnt_advance = (state_q != ST_IDLE);

        rd_buf_d = swap ? wr_buf_q : rd_buf_q;
        wr_buf_d = swap ? rd_buf_q : wr_buf_q;

        if (frame_start) begin
            rd_addr_d = '0;
        end else if ((state_q == ST_ACTIVE) && chan_tc) begin
            rd_addr_d = rd_addr_q + AW'(1);
        end else begin
            rd_addr_d = rd_addr_q;
        end

        vb_d = frame_start ? vb_lines : vb_q;
        hb_d = frame_start ? hb_px    : hb_q;
        ap_d = frame_start ? ap_in    : ap_q;
        al_d = frame_start ? al_in    : al_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            vb_q        <= '0;
            hb_q        <= '0;
            ap_q        <= '0;
            al_q        <= '0;
            rd_buf_q    <= BUF_1;
            wr_buf_q    <= BUF_0;
            buf_empty_q <= BUF_ALL_EMPTY;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            blank_q     <= 1'b1;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            vb_q        <= vb_d;
            hb_q        <= hb_d;
            ap_q        <= ap_d;
            al_q        <= al_d;
            rd_buf_q    <= rd_buf_d;
            wr_buf_q    <= wr_buf_d;
            buf_empty_q <= buf_empty_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            blank_q     <= blank_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign rd_buf    = rd_buf_q;
    assign wr_buf    = wr_buf_q;
    assign buf_empty = buf_empty_q;
    assign chan_sel  = chan;
    assign blank     = blank_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;

endmodule
